// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory request/response bus plus decode-side valid/ready head.
interface fetch_prefetch_queue_if #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned INSTR_W = 16
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_rdy;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;
   logic               out_valid;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic [ADDR_W-1:0]  out_pc_next;
   logic               out_ready;

   // Fetch unit side
   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next,
      input  imem_rdy, imem_rvalid, imem_rdata, out_ready
   );

   // Memory / decode side
   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next,
      output imem_rdy, imem_rvalid, imem_rdata, out_ready
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding memory request at a time,
// returned instructions tagged with their PC in a DEPTH-entry FIFO for decode.
// A redirect flushes the FIFO and turns an in-flight request into a discard.
module fetch_prefetch_queue #(
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       INSTR_W  = 16,
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       PC_INC   = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect,
   input  logic [ADDR_W-1:0]     redirect_pc,
   input  logic                  halt,
   output logic                  err,
   fetch_prefetch_queue_if.master bus
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } state_t;

   state_t             state_q,    state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  req_pc_q,   req_pc_d;
   logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [CNT_W-1:0]   count_q,    count_d;
   logic               err_q,      err_d;
   logic               live_q;

   logic [INSTR_W-1:0] instr_mem_q [DEPTH];
   logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

   logic               req;
   logic               accept;
   logic               push;
   logic               pop;
   logic               valid;
   logic [ADDR_W:0]    pc_sum;

   // Request, handshake and FIFO strobes from registered state and live inputs
   always_comb begin
      // live_q holds requests off for the first cycle after reset
      req    = live_q && rst && (state_q == IDLE) && !halt && !redirect
               && (count_q < CNT_W'(DEPTH));
      accept = req && bus.imem_rdy;
      valid  = rst && (count_q != '0);
      pop    = valid && bus.out_ready && !redirect;
      push   = rst && !redirect && (state_q == WAIT) && bus.imem_rvalid;
      pc_sum = {1'b0, fetch_pc_q} + (ADDR_W+1)'(PC_INC);
   end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = fetch_pc_q;
   assign bus.out_valid   = valid;
   assign bus.out_instr   = instr_mem_q[rd_ptr_q];
   assign bus.out_pc      = pc_mem_q[rd_ptr_q];
   assign bus.out_pc_next = pc_mem_q[rd_ptr_q] + ADDR_W'(PC_INC);
   assign err             = err_q;

   // Next-state: redirect dominates, otherwise FSM step plus FIFO bookkeeping
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      err_d      = err_q;

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         wr_ptr_d   = rd_ptr_q;
         count_d    = '0;
         case (state_q)
            WAIT:    state_d = bus.imem_rvalid ? IDLE : DROP;
            DROP:    state_d = bus.imem_rvalid ? IDLE : DROP;
            default: state_d = IDLE;
         endcase
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_d    = WAIT;
                  req_pc_d   = fetch_pc_q;
                  fetch_pc_d = pc_sum[ADDR_W-1:0];
                  if (pc_sum[ADDR_W]) begin
                     err_d = 1'b1;
                  end
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  state_d = IDLE;
               end
            end
            DROP: begin
               if (bus.imem_rvalid) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase

         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
         live_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         err_q      <= err_d;
         live_q     <= 1'b1;
      end
   end

   // FIFO storage; contents are don't-care while the slot is not counted
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
         pc_mem_q[wr_ptr_q]    <= req_pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench: a latency-configurable memory model feeds the fetch unit,
// kept responses are queued as expected {instr, pc} and compared on each pop.
module tb_fetch_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        err;
   logic        w_halt;
   logic        w_redir;
   logic [15:0] w_rpc;
   logic        w_err;

   always #5 clk = ~clk;

   fetch_prefetch_queue_if #(.ADDR_W(16), .INSTR_W(16)) bus  ();
   fetch_prefetch_queue_if #(.ADDR_W(16), .INSTR_W(16)) wbus ();

   fetch_prefetch_queue #(
      .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .PC_INC(2), .RESET_PC(16'h0000)
   ) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .halt(halt), .err(err), .bus(bus)
   );

   fetch_prefetch_queue #(
      .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .PC_INC(2), .RESET_PC(16'hFFFE)
   ) wdut (
      .clk(clk), .rst(rst), .redirect(w_redir), .redirect_pc(w_rpc),
      .halt(w_halt), .err(w_err), .bus(wbus)
   );

   int          checks   = 0;
   int          failures = 0;

   logic [31:0] sb [$];
   logic [15:0] acc_log [$];
   int          acc_cnt  = 0;
   bit          mem_busy = 0;
   bit          mem_kill = 0;
   int          mem_cnt  = 0;
   int          mem_lat  = 1;
   logic [15:0] mem_addr = '0;
   logic [15:0] exp_pc   = '0;
   bit          exp_err  = 0;
   bit          fresh    = 0;
   bit          w_watch  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive memory, check outputs mid-cycle, advance the model
   task automatic cycle();
      logic        exp_req, pop, acc, rv;
      logic [15:0] acc_addr, nx;
      logic [31:0] head;
      @(negedge clk);
      rv = mem_busy && (mem_cnt == 0);
      bus.imem_rvalid = rv;
      bus.imem_rdata  = mem_addr ^ 16'hA5A5;
      #1;
      exp_req = !fresh && !mem_busy && !halt && !redirect && (sb.size() < 4);
      check("imem_req", bus.imem_req, exp_req);
      check("out_valid", bus.out_valid, sb.size() != 0);
      check("err", err, exp_err);
      if (bus.imem_req) check("imem_addr", bus.imem_addr, exp_pc);
      if (w_watch) begin
         check("w_req", wbus.imem_req, !fresh);
         if (wbus.imem_req) check("w_addr", wbus.imem_addr, 16'hFFFE);
         check("w_err", w_err, 0);
      end
      pop = bus.out_valid && bus.out_ready && !redirect;
      if (pop && sb.size() != 0) begin
         head = sb[0];
         nx   = head[15:0] + 16'd2;
         check("out_pc", bus.out_pc, head[15:0]);
         check("out_instr", bus.out_instr, head[31:16]);
         check("out_pc_next", bus.out_pc_next, nx);
      end
      acc      = bus.imem_req && bus.imem_rdy;
      acc_addr = bus.imem_addr;
      @(posedge clk);
      #1;
      fresh = 0;
      if (redirect) begin
         sb.delete();
         exp_pc = redirect_pc;
         if (mem_busy && !rv) mem_kill = 1;
      end else begin
         if (pop && sb.size() != 0) void'(sb.pop_front());
         if (rv && !mem_kill) sb.push_back({mem_addr ^ 16'hA5A5, mem_addr});
         if (acc) begin
            if ({1'b0, exp_pc} + 17'd2 > 17'h0FFFF) exp_err = 1;
            exp_pc = exp_pc + 16'd2;
         end
      end
      if (rv) begin
         mem_busy = 0;
         mem_kill = 0;
      end else if (mem_busy) begin
         mem_cnt--;
      end
      if (acc) begin
         mem_busy = 1;
         mem_cnt  = mem_lat - 1;
         mem_addr = acc_addr;
         acc_cnt++;
         acc_log.push_back(acc_addr);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b0;
      bus.imem_rvalid  = 1'b0;
      wbus.imem_rvalid = 1'b0;
      #1;
      check("rst_req", bus.imem_req, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_w_req", wbus.imem_req, 0);
      check("rst_w_valid", wbus.out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_req2", bus.imem_req, 0);
      check("rst_valid2", bus.out_valid, 0);
      check("rst_err", err, 0);
      check("rst_w_err", w_err, 0);
      check("rst_w_valid2", wbus.out_valid, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      exp_pc   = 16'h0000;
      exp_err  = 0;
      mem_busy = 0;
      mem_kill = 0;
      fresh    = 1;
   endtask

   initial begin
      int n;
      bit hit;
      rst = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
      w_halt = 1'b1; w_redir = 1'b0; w_rpc = '0;
      bus.imem_rdy = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.out_ready = 1'b1;
      wbus.imem_rdy = 1'b1; wbus.imem_rvalid = 1'b0; wbus.imem_rdata = '0; wbus.out_ready = 1'b0;

      // Sequential fetch with 1-cycle memory
      reset_pulse();
      acc_log.delete();
      for (int i = 0; i < 12; i++) cycle();
      check("a_nacc", acc_log.size() >= 3, 1);
      if (acc_log.size() >= 3) begin
         check("a_addr0", acc_log[0], 16'h0000);
         check("a_addr1", acc_log[1], 16'h0002);
         check("a_addr2", acc_log[2], 16'h0004);
      end

      // Back-pressure fills the FIFO, one pop frees exactly one credit
      bus.out_ready = 1'b0;
      for (int i = 0; i < 14; i++) cycle();
      check("b_full_cnt", sb.size(), 4);
      n = acc_cnt;
      bus.out_ready = 1'b1;
      cycle();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      check("b_one_refill", acc_cnt - n, 1);

      // Latency 3 with a redirect in the second wait cycle
      halt = 1'b1; bus.out_ready = 1'b1;
      hit = 0;
      for (int i = 0; i < 30 && !hit; i++) begin
         cycle();
         hit = !mem_busy && (sb.size() == 0);
      end
      check("c_drain_tmo", hit, 1);
      halt = 1'b0; mem_lat = 3;
      cycle();
      check("c_accept", mem_busy, 1);
      cycle();
      redirect = 1'b1; redirect_pc = 16'h0100;
      cycle();
      redirect = 1'b0;
      acc_log.delete();
      for (int i = 0; i < 14; i++) cycle();
      check("c_nacc", acc_log.size() >= 1, 1);
      if (acc_log.size() >= 1) check("c_addr", acc_log[0], 16'h0100);

      // Redirect coinciding with a response and a pop
      mem_lat = 1; bus.out_ready = 1'b0;
      hit = 0;
      for (int i = 0; i < 30 && !hit; i++) begin
         hit = mem_busy && (mem_cnt == 0) && (sb.size() >= 1);
         if (!hit) cycle();
      end
      check("d_setup_tmo", hit, 1);
      redirect = 1'b1; redirect_pc = 16'h0040; bus.out_ready = 1'b1;
      acc_log.delete();
      cycle();
      redirect = 1'b0;
      check("d_flushed", sb.size(), 0);
      for (int i = 0; i < 6; i++) cycle();
      check("d_nacc", acc_log.size() >= 1, 1);
      if (acc_log.size() >= 1) check("d_addr", acc_log[0], 16'h0040);

      // Halt while a request is in flight
      mem_lat = 2;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         cycle();
         hit = mem_busy;
      end
      check("e_busy_tmo", hit, 1);
      halt = 1'b1;
      n = acc_cnt;
      for (int i = 0; i < 6; i++) cycle();
      check("e_halt_noreq", acc_cnt - n, 0);
      halt = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      check("e_resume", acc_cnt - n >= 2, 1);

      // Address wrap on the RESET_PC=0xFFFE instance
      halt = 1'b1; bus.out_ready = 1'b0;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         cycle();
         hit = !mem_busy;
      end
      check("f_idle_tmo", hit, 1);
      w_halt = 1'b0;
      @(negedge clk); #1;
      check("w_req_first", wbus.imem_req, 1);
      check("w_addr_first", wbus.imem_addr, 16'hFFFE);
      check("w_err_pre", w_err, 0);
      @(posedge clk); #1; w_halt = 1'b1;
      @(negedge clk); wbus.imem_rvalid = 1'b1; wbus.imem_rdata = 16'h1234; #1;
      check("w_req_wait", wbus.imem_req, 0);
      check("w_err_set", w_err, 1);
      @(posedge clk); #1; wbus.imem_rvalid = 1'b0;
      @(negedge clk); w_halt = 1'b0; #1;
      check("w_valid", wbus.out_valid, 1);
      check("w_out_pc", wbus.out_pc, 16'hFFFE);
      check("w_pc_next", wbus.out_pc_next, 16'h0000);
      check("w_instr", wbus.out_instr, 16'h1234);
      check("w_addr_wrap", wbus.imem_addr, 16'h0000);
      check("w_req_wrap", wbus.imem_req, 1);
      @(posedge clk); #1; w_halt = 1'b1; w_redir = 1'b1; w_rpc = 16'h0040;
      @(negedge clk); #1;
      check("w_req_redir", wbus.imem_req, 0);
      @(posedge clk); #1; w_redir = 1'b0;
      @(negedge clk); wbus.imem_rvalid = 1'b1; wbus.imem_rdata = 16'hDEAD; #1;
      check("w_flushed", wbus.out_valid, 0);
      check("w_err_redir", w_err, 1);
      @(posedge clk); #1; wbus.imem_rvalid = 1'b0;
      @(negedge clk); w_halt = 1'b0; #1;
      check("w_dropped", wbus.out_valid, 0);
      check("w_addr_redir", wbus.imem_addr, 16'h0040);
      check("w_req_redir2", wbus.imem_req, 1);
      check("w_err_sticky", w_err, 1);
      @(posedge clk); #1; w_halt = 1'b1;

      // Mid-stream reset clears FIFO, err and request state
      halt = 1'b0; mem_lat = 1;
      for (int i = 0; i < 6; i++) cycle();
      w_halt = 1'b0; wbus.imem_rdy = 1'b0;
      reset_pulse();
      w_watch = 1;
      for (int i = 0; i < 3; i++) cycle();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
